// File: rtl/rv32i_decode_stage_pkg.sv
// Shared RV32I decode types: control-field enums, the decoded record and
// opcode/funct constants used by the decoder and the decode-stage FIFO.
package rv32i_decode_stage_pkg;

    typedef enum logic [4:0] {
        ALU_NOP   = 5'd0,
        ALU_ADD   = 5'd1,
        ALU_SUB   = 5'd2,
        ALU_SLL   = 5'd3,
        ALU_SLT   = 5'd4,
        ALU_SLTU  = 5'd5,
        ALU_XOR   = 5'd6,
        ALU_SRL   = 5'd7,
        ALU_SRA   = 5'd8,
        ALU_OR    = 5'd9,
        ALU_AND   = 5'd10,
        ALU_BEQ   = 5'd11,
        ALU_BNE   = 5'd12,
        ALU_BLT   = 5'd13,
        ALU_BGE   = 5'd14,
        ALU_BLTU  = 5'd15,
        ALU_BGEU  = 5'd16,
        ALU_CSRRW = 5'd17,
        ALU_CSRRS = 5'd18,
        ALU_CSRRC = 5'd19
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_INPUT1_NONE = 3'd0,
        ALU_INPUT1_RS1  = 3'd1,
        ALU_INPUT1_PC   = 3'd2,
        ALU_INPUT1_CSR  = 3'd3,
        ALU_INPUT1_IMM  = 3'd4
    } alu_input1_type_e;

    // RS1 on input 2 carries the source operand of register-form CSR ops
    typedef enum logic [1:0] {
        ALU_INPUT2_NONE = 2'd0,
        ALU_INPUT2_RS2  = 2'd1,
        ALU_INPUT2_IMM  = 2'd2,
        ALU_INPUT2_RS1  = 2'd3
    } alu_input2_type_e;

    typedef enum logic [2:0] {
        WB_NONE = 3'd0,
        WB_ALU  = 3'd1,
        WB_MEM  = 3'd2,
        WB_PC   = 3'd3,
        WB_CSR  = 3'd4
    } wb_from_e;

    typedef enum logic [1:0] {
        BRANCH_NONE     = 2'd0,
        BRANCH_RELATIVE = 2'd1,
        BRANCH_ABSOLUTE = 2'd2
    } branch_type_e;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } mem_op_e;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_NONE = 3'd6
    } imm_type_e;

    typedef struct packed {
        logic [31:0]      pc;
        alu_op_e          alu_op;
        alu_input1_type_e alu_in1;
        alu_input2_type_e alu_in2;
        wb_from_e         wb_from;
        branch_type_e     branch;
        logic             mem_en;
        mem_op_e          mem_op;
        logic [2:0]       funct3;
        logic             reg_we;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [31:0]      imm;
        logic [11:0]      csr_addr;
        logic             illegal;
    } decoded_inst_s;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // Immediate generation for every RV32I format
    function automatic logic [31:0] gen_imm(input imm_type_e t, input logic [31:0] inst);
        logic [31:0] v;
        case (t)
            IMM_I:   v = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   v = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   v = {inst[31:12], 12'b0};
            IMM_J:   v = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_Z:   v = {27'b0, inst[19:15]};
            default: v = 32'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rv32i_decode_stage_comb.sv
// Purely combinational RV32I decoder: raw instruction word -> decoded record.
module rv32i_decode_comb
    import rv32i_decode_stage_pkg::*;
#(
    parameter bit ENABLE_ZICSR = 1'b1,
    parameter bit ENABLE_FENCE = 1'b1
) (
    input  logic [31:0]   i_inst,
    input  logic [31:0]   i_pc,
    output decoded_inst_s o_dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;

    assign w_opcode = i_inst[6:0];
    assign w_f3     = i_inst[14:12];
    assign w_f7     = i_inst[31:25];

    alu_op_e          w_alu_op;
    alu_input1_type_e w_in1;
    alu_input2_type_e w_in2;
    wb_from_e         w_wb;
    branch_type_e     w_br;
    logic             w_mem_en;
    mem_op_e          w_mem_op;
    imm_type_e        w_imm_type;
    logic             w_illegal;

    // Classify the opcode and select control fields; anything unmatched is illegal
    always_comb begin
        w_alu_op   = ALU_NOP;
        w_in1      = ALU_INPUT1_NONE;
        w_in2      = ALU_INPUT2_NONE;
        w_wb       = WB_NONE;
        w_br       = BRANCH_NONE;
        w_mem_en   = 1'b0;
        w_mem_op   = MEM_LOAD;
        w_imm_type = IMM_NONE;
        w_illegal  = 1'b0;
        if (i_inst[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end else begin
            case (w_opcode)
                OPC_LUI: begin
                    w_alu_op = ALU_ADD; w_in1 = ALU_INPUT1_IMM; w_in2 = ALU_INPUT2_NONE;
                    w_wb = WB_ALU; w_imm_type = IMM_U;
                end
                OPC_AUIPC: begin
                    w_alu_op = ALU_ADD; w_in1 = ALU_INPUT1_PC; w_in2 = ALU_INPUT2_IMM;
                    w_wb = WB_ALU; w_imm_type = IMM_U;
                end
                OPC_JAL: begin
                    w_alu_op = ALU_ADD; w_in1 = ALU_INPUT1_PC; w_in2 = ALU_INPUT2_IMM;
                    w_wb = WB_PC; w_br = BRANCH_RELATIVE; w_imm_type = IMM_J;
                end
                OPC_JALR: begin
                    w_alu_op = ALU_ADD; w_in1 = ALU_INPUT1_RS1; w_in2 = ALU_INPUT2_IMM;
                    w_wb = WB_PC; w_br = BRANCH_ABSOLUTE; w_imm_type = IMM_I;
                    w_illegal = (w_f3 != 3'b000);
                end
                OPC_BRANCH: begin
                    w_in1 = ALU_INPUT1_RS1; w_in2 = ALU_INPUT2_RS2;
                    w_br = BRANCH_RELATIVE; w_imm_type = IMM_B;
                    case (w_f3)
                        F3_BEQ:  w_alu_op = ALU_BEQ;
                        F3_BNE:  w_alu_op = ALU_BNE;
                        F3_BLT:  w_alu_op = ALU_BLT;
                        F3_BGE:  w_alu_op = ALU_BGE;
                        F3_BLTU: w_alu_op = ALU_BLTU;
                        F3_BGEU: w_alu_op = ALU_BGEU;
                        default: w_illegal = 1'b1;
                    endcase
                end
                OPC_LOAD: begin
                    w_alu_op = ALU_ADD; w_in1 = ALU_INPUT1_RS1; w_in2 = ALU_INPUT2_IMM;
                    w_wb = WB_MEM; w_mem_en = 1'b1; w_mem_op = MEM_LOAD; w_imm_type = IMM_I;
                    w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
                end
                OPC_STORE: begin
                    w_alu_op = ALU_ADD; w_in1 = ALU_INPUT1_RS1; w_in2 = ALU_INPUT2_IMM;
                    w_mem_en = 1'b1; w_mem_op = MEM_STORE; w_imm_type = IMM_S;
                    w_illegal = (w_f3 > 3'b010);
                end
                OPC_OPIMM: begin
                    w_in1 = ALU_INPUT1_RS1; w_in2 = ALU_INPUT2_IMM;
                    w_wb = WB_ALU; w_imm_type = IMM_I;
                    case (w_f3)
                        F3_ADD_SUB: w_alu_op = ALU_ADD;
                        F3_SLT:     w_alu_op = ALU_SLT;
                        F3_SLTU:    w_alu_op = ALU_SLTU;
                        F3_XOR:     w_alu_op = ALU_XOR;
                        F3_OR:      w_alu_op = ALU_OR;
                        F3_AND:     w_alu_op = ALU_AND;
                        F3_SLL: begin
                            if (w_f7 == F7_BASE) w_alu_op = ALU_SLL;
                            else                 w_illegal = 1'b1;
                        end
                        default: begin
                            if (w_f7 == F7_BASE)     w_alu_op = ALU_SRL;
                            else if (w_f7 == F7_ALT) w_alu_op = ALU_SRA;
                            else                     w_illegal = 1'b1;
                        end
                    endcase
                end
                OPC_OP: begin
                    w_in1 = ALU_INPUT1_RS1; w_in2 = ALU_INPUT2_RS2; w_wb = WB_ALU;
                    if (w_f7 == F7_BASE) begin
                        case (w_f3)
                            F3_ADD_SUB: w_alu_op = ALU_ADD;
                            F3_SLL:     w_alu_op = ALU_SLL;
                            F3_SLT:     w_alu_op = ALU_SLT;
                            F3_SLTU:    w_alu_op = ALU_SLTU;
                            F3_XOR:     w_alu_op = ALU_XOR;
                            F3_SR:      w_alu_op = ALU_SRL;
                            F3_OR:      w_alu_op = ALU_OR;
                            default:    w_alu_op = ALU_AND;
                        endcase
                    end else if (w_f7 == F7_ALT && w_f3 == F3_ADD_SUB) begin
                        w_alu_op = ALU_SUB;
                    end else if (w_f7 == F7_ALT && w_f3 == F3_SR) begin
                        w_alu_op = ALU_SRA;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OPC_FENCE: begin
                    // Fences are treated as no-ops in this in-order pipeline
                    w_illegal = !ENABLE_FENCE;
                end
                OPC_SYSTEM: begin
                    if (w_f3 != 3'b000) begin
                        if (!ENABLE_ZICSR || w_f3[1:0] == 2'b00) begin
                            w_illegal = 1'b1;
                        end else begin
                            w_in1 = ALU_INPUT1_CSR;
                            w_wb  = WB_CSR;
                            w_in2 = w_f3[2] ? ALU_INPUT2_IMM : ALU_INPUT2_RS1;
                            w_imm_type = w_f3[2] ? IMM_Z : IMM_NONE;
                            case (w_f3[1:0])
                                2'b01:   w_alu_op = ALU_CSRRW;
                                2'b10:   w_alu_op = ALU_CSRRS;
                                default: w_alu_op = ALU_CSRRC;
                            endcase
                        end
                    end
                end
                default: w_illegal = 1'b1;
            endcase
        end
    end

    // Assemble the record; illegal words are forced to a harmless bubble
    always_comb begin
        o_dec          = '0;
        o_dec.pc       = i_pc;
        o_dec.funct3   = w_f3;
        o_dec.rd       = i_inst[11:7];
        o_dec.rs1      = i_inst[19:15];
        o_dec.rs2      = i_inst[24:20];
        o_dec.imm      = gen_imm(w_imm_type, i_inst);
        o_dec.csr_addr = i_inst[31:20];
        o_dec.mem_op   = w_mem_op;
        o_dec.illegal  = w_illegal;
        if (!w_illegal) begin
            o_dec.alu_op  = w_alu_op;
            o_dec.alu_in1 = w_in1;
            o_dec.alu_in2 = w_in2;
            o_dec.wb_from = w_wb;
            o_dec.branch  = w_br;
            o_dec.mem_en  = w_mem_en;
            o_dec.reg_we  = (w_wb != WB_NONE) && (i_inst[11:7] != 5'd0);
        end
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// RV32I decode stage: combinational decode into a DEPTH-entry FIFO of
// decoded records with valid/ready handshakes on both sides and flush.
module rv32i_decode_stage
    import rv32i_decode_stage_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter bit ENABLE_ZICSR = 1'b1,
    parameter bit ENABLE_FENCE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_alu_op,
    output logic [2:0]  out_alu_in1,
    output logic [1:0]  out_alu_in2,
    output logic [2:0]  out_wb_from,
    output logic [1:0]  out_branch,
    output logic        out_mem_en,
    output logic        out_mem_op,
    output logic [2:0]  out_funct3,
    output logic        out_reg_we,
    output logic [4:0]  out_rd,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [31:0] out_imm,
    output logic [11:0] out_csr_addr,
    output logic        out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    decoded_inst_s    w_dec;
    decoded_inst_s    w_head;
    decoded_inst_s    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    rv32i_decode_comb #(
        .ENABLE_ZICSR (ENABLE_ZICSR),
        .ENABLE_FENCE (ENABLE_FENCE)
    ) u_decode (
        .i_inst (in_inst),
        .i_pc   (in_pc),
        .o_dec  (w_dec)
    );

    assign w_full    = (r_count == FULL_CNT);
    // No pass-through: a full FIFO refuses input even when popping this cycle
    assign in_ready  = !reset && !w_full;
    assign out_valid = !reset && (r_count != '0);
    // Flush discards both the incoming word and any pop this cycle
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    // Pointer and occupancy tracking; reset beats flush, flush beats push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage for decoded records; only written on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_dec;
    end

    // Zero the head fields whenever no entry is presented
    always_comb begin
        w_head = '0;
        if (out_valid) w_head = r_mem[r_rd_ptr];
    end

    assign out_pc       = w_head.pc;
    assign out_alu_op   = w_head.alu_op;
    assign out_alu_in1  = w_head.alu_in1;
    assign out_alu_in2  = w_head.alu_in2;
    assign out_wb_from  = w_head.wb_from;
    assign out_branch   = w_head.branch;
    assign out_mem_en   = w_head.mem_en;
    assign out_mem_op   = w_head.mem_op;
    assign out_funct3   = w_head.funct3;
    assign out_reg_we   = w_head.reg_we;
    assign out_rd       = w_head.rd;
    assign out_rs1      = w_head.rs1;
    assign out_rs2      = w_head.rs2;
    assign out_imm      = w_head.imm;
    assign out_csr_addr = w_head.csr_addr;
    assign out_illegal  = w_head.illegal;

endmodule
